// File: rtl/wb_regfile.sv
// MEM/WB stage register, 32x32 register file with two combinational read ports
// and a committed-write counter. Define REGFILE_BYPASS_EN for WB-to-read bypass.
module wb_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic        re1_i,
  input  logic [4:0]  raddr1_i,
  output logic [31:0] rdata1_o,
  input  logic        re2_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata2_o,
  output logic [4:0]  wb_wd_o,
  output logic        wb_wreg_o,
  output logic [31:0] wb_wdata_o,
  output logic [31:0] wb_cnt_o
);

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 32;

  // Set only by a fresh load, so a stalled instruction is counted once.
  logic          wb_new;
  logic          commit_c;
  logic [DW-1:0] regs [1:NREG-1];

  assign commit_c = wb_wreg_o && (wb_wd_o != '0);

  // MEM/WB stage register: rst/flush clear, stall holds, otherwise load.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wb_wd_o    <= '0;
      wb_wreg_o  <= 1'b0;
      wb_wdata_o <= '0;
      wb_new     <= 1'b0;
    end else if (stall_i) begin
      wb_new     <= 1'b0;
    end else begin
      wb_wd_o    <= wd_i;
      wb_wreg_o  <= wreg_i;
      wb_wdata_o <= wdata_i;
      wb_new     <= 1'b1;
    end
  end

  // Register array write; re-writing the held value during a stall is harmless.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 1; i < NREG; i++) begin
        regs[AW'(i)] <= '0;
      end
    end else if (commit_c) begin
      regs[wb_wd_o] <= wb_wdata_o;
    end
  end

  // Committed-write counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_cnt_o <= '0;
    end else if (wb_new && commit_c) begin
      wb_cnt_o <= wb_cnt_o + DW'(1);
    end
  end

  // Read port 1.
  always_comb begin
    rdata1_o = '0;
    if (!rst && re1_i && (raddr1_i != '0)) begin
`ifdef REGFILE_BYPASS_EN
      if (wb_wreg_o && (raddr1_i == wb_wd_o)) begin
        rdata1_o = wb_wdata_o;
      end else begin
        rdata1_o = regs[raddr1_i];
      end
`else
      rdata1_o = regs[raddr1_i];
`endif
    end
  end

  // Read port 2.
  always_comb begin
    rdata2_o = '0;
    if (!rst && re2_i && (raddr2_i != '0)) begin
`ifdef REGFILE_BYPASS_EN
      if (wb_wreg_o && (raddr2_i == wb_wd_o)) begin
        rdata2_o = wb_wdata_o;
      end else begin
        rdata2_o = regs[raddr2_i];
      end
`else
      rdata2_o = regs[raddr2_i];
`endif
    end
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL provide the following ports:
 clk  in  1  rising-edge clock
 rst  in  1  reset
 stall_i  in  1  hold MEM/WB stage register
 flush_i  in  1  squash MEM/WB stage register
 wd_i  in  5  destination register address from MEM stage
 wreg_i  in  1  write-enable from MEM stage
 wdata_i  in  32  write data from MEM stage
 re1_i  in  1  read port 1 enable
 raddr1_i  in  5  read port 1 address
 rdata1_o  out  32  read port 1 data
 re2_i  in  1  read port 2 enable
 raddr2_i  in  5  read port 2 address
 rdata2_o  out  32  read port 2 data
 wb_wd_o  out  5  registered WB destination address
 wb_wreg_o  out  1  registered WB write-enable
 wb_wdata_o  out  32  registered WB data
 wb_cnt_o  out  32  count of committed register writes
REQ-002 Reset rst SHALL be synchronous, active-high.

Function
REQ-003 The MEM/WB stage register SHALL update on the clk rising edge with the following priority: rst, then flush_i, then stall_i, then load.
 - rst or flush_i: wb_wd_o=0, wb_wreg_o=0, wb_wdata_o=0.
 - stall_i (no flush): all stage outputs hold their value.
 - otherwise: capture wd_i, wreg_i and wdata_i.
REQ-004 An internal flag wb_new SHALL be set to 1 on a load and cleared to 0 on stall, flush or rst.
REQ-005 The register file SHALL contain 32 x 32-bit registers; register 0 SHALL always read as 0 and SHALL never be written.
REQ-006 On each clk rising edge with rst=0, wb_wreg_o=1 and wb_wd_o!=0, the block SHALL write wb_wdata_o into regs[wb_wd_o]. Repeated writes during a stall are idempotent.
REQ-007 Write latency SHALL be as follows:
 - data presented on wd_i/wdata_i before edge N appears on wb_*_o after edge N;
 - that data is stored in the array at edge N+1.
REQ-008 Read ports SHALL be combinational and independent. For each port the priority is:
 - rst=1 -> 0;
 - re=0 -> 0;
 - raddr=0 -> 0;
 - bypass hit (REQ-013) -> wb_wdata_o;
 - otherwise -> regs[raddr].
REQ-009 Both ports reading the same address SHALL return identical data.
REQ-010 wb_cnt_o SHALL increment by 1 at a clk edge only when wb_new=1, wb_wreg_o=1 and wb_wd_o!=0 before that edge, so that each committed write is counted exactly once.
 - A stalled instruction is not recounted.
 - The counter wraps from 0xFFFFFFFF to 0x00000000.
REQ-011 flush_i and stall_i asserted together SHALL behave as flush.

Reset
REQ-012 At a clk edge with rst=1, the block SHALL clear all stage outputs, wb_new, wb_cnt_o and registers 1..31 to 0. Reset asserted mid-stall or mid-write discards the pending write, and rdata1_o/rdata2_o read 0 while rst=1.

Configuration
REQ-013 Macro REGFILE_BYPASS_EN SHALL control write-to-read bypass.
 - Defined: a port with re=1, raddr!=0, raddr==wb_wd_o and wb_wreg_o=1 SHALL return wb_wdata_o in the same cycle.
 - Undefined: no bypass; the port SHALL return the array content, which is the old value until edge N+1, and the hazard logic upstream is responsible for covering the gap.

Verification
REQ-014 A bench SHALL cover the following directed scenarios:
 - Load wd_i=5, wreg_i=1, wdata_i=0xDEADBEEF with re1_i=1, raddr1_i=5: after edge 1, rdata1_o=0xDEADBEEF with REGFILE_BYPASS_EN and the old value (0) without it; after edge 2, rdata1_o=0xDEADBEEF in both builds; wb_cnt_o=1.
 - Write wd_i=0, wreg_i=1, wdata_i=0x12345678, then read raddr1_i=0 and raddr2_i=0: both rdata=0; wb_cnt_o unchanged.
 - Load a write to reg 7, then hold stall_i=1 for 3 cycles: wb_*_o hold, reg 7=data, wb_cnt_o increments exactly once (by 1).
 - Assert stall_i=1 and flush_i=1 in the same cycle with a pending write to reg 9: wb_wreg_o=0 after the edge; if the edge-1 write of reg 9 has not yet occurred, reg 9 is not written.
 - Force wb_cnt_o to 0xFFFFFFFF, then commit one write: wb_cnt_o=0x00000000.
 - Write regs 1..31 with nonzero values, then assert rst for 1 cycle: all reads return 0 afterwards and wb_cnt_o=0.
